regfile_wb_ctrl: RTL and testbench
==================================

# regfile_wb_ctrl

Write-port controller for the integer register file. It shares the register file's single synchronous write port between two writeback sources: the in-order pipeline (port A) and the long-latency execution unit (port B, e.g. multiply/divide/load-miss). It also keeps a per-register busy scoreboard for results still owed by port B, which issue logic queries for hazards. It sits between the writeback stage and the register file, and drives the register file's RdWriteEnable/RdWriteAddr/RdWriteData inputs from flops.

## Interface
Parameters:
- DATA_W, 64, writeback data width (matches the data bus)
- ADDR_W, 5, register address width
- REG_NUM, 32, number of architectural registers

Ports:
- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- AValid  in  1  pipeline writeback request
- AAddr  in  ADDR_W  pipeline destination register
- AData  in  DATA_W  pipeline result
- AReady  out  1  port A accepted this cycle
- BValid  in  1  long-latency writeback request
- BAddr  in  ADDR_W  long-latency destination register
- BData  in  DATA_W  long-latency result
- BReady  out  1  port B accepted this cycle
- IssueValid  in  1  long-latency op dispatched; its destination becomes busy
- IssueAddr  in  ADDR_W  destination of dispatched long-latency op
- IssueReady  out  1  dispatch permitted (no write-after-write on IssueAddr)
- Rs1Addr, Rs2Addr  in  ADDR_W  source registers to check
- Rs1Busy, Rs2Busy  out  1  source register has a pending port-B write
- RdWriteEnable  out  1  to register file
- RdWriteAddr  out  ADDR_W  to register file
- RdWriteData  out  DATA_W  to register file

## Operation
- Reset: RdWriteEnable=0, RdWriteAddr=0, RdWriteData=0, all busy bits=0, round-robin pointer=B (so A wins the first contention).
- Arbitration (combinational grant): only A valid -> grant A. Only B valid -> grant B. Both valid -> grant the port not named by the pointer, then set the pointer to the granted port. The pointer updates only on contention.
- AReady/BReady equal the grant and depend on the other port's Valid. A request is accepted when Valid&&Ready in the same cycle. A requester holds Addr/Data stable until accepted.
- Accepted write: on the next edge, RdWriteEnable=1, RdWriteAddr/RdWriteData = granted addr/data. With no grant, RdWriteEnable=0 and addr/data hold their last values.
- Address 0: the write is accepted (Ready asserts) but RdWriteEnable stays 0.
- Scoreboard: busy[IssueAddr] is set on IssueValid&&IssueReady when IssueAddr!=0. busy[BAddr] is cleared on B acceptance.
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is always 0.
- IssueReady = !busy[IssueAddr] (combinational).
- RsNBusy = busy[RsNAddr] (combinational, registered state only). There is no bypass: a register cleared this cycle still reads busy.
- An A write to a busy register is performed anyway. Ordering is owned by issue logic.

## Timing
- Accept-to-RdWriteEnable latency: 1 cycle. Sustained throughput is 1 write per cycle.
- Busy appears 1 cycle after issue and clears 1 cycle after B acceptance. The register file sees the data on that same edge.
- Worst-case wait under continuous contention is 1 cycle per port (strict alternation).
- Reset mid-operation clears outputs and the scoreboard immediately (asynchronous). In-flight writes are lost and requesters re-present after reset.

## Structure
- Shared defines supply DATA_W/ADDR_W/REG_NUM defaults and the zero-register constant. Do not redefine them locally.
- One sub-module, wb_rr_arbiter: a 2-way round-robin arbiter holding the pointer flop. The top level holds the scoreboard and output flops.

## Test plan
- Reset: drive Rst=0 mid-traffic -> all outputs 0 and busy all 0 within the same cycle. First contention after release grants A.
- Single port: AValid, AAddr=5, AData=0x1234 -> AReady=1. Next cycle RdWriteEnable=1, RdWriteAddr=5, RdWriteData=0x1234.
- Contention: A (x3, 0xAA) and B (x4, 0xBB) valid for 4 cycles -> grants A,B,A,B. Writes appear one cycle later in that order.
- Scoreboard: issue x7 -> Rs1Addr=7 gives Rs1Busy=1 next cycle and IssueReady=0 for x7. B writes x7 -> busy clears the cycle after acceptance.
- Same-cycle set/clear: B accepted to x9 while IssueValid to x9 -> busy[9] stays 1.
- Zero register: issue x0 -> Busy never asserts. A write to x0 -> AReady=1, RdWriteEnable stays 0.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared defaults for the register-file writeback controller.
// Data/address widths, register count, zero-register id, port tags.
package regfile_wb_ctrl_pkg;

  localparam int WB_DATA_W  = 64;
  localparam int WB_ADDR_W  = 5;
  localparam int WB_REG_NUM = 32;

  localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

  // Round-robin pointer value: port that won the last contention.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } wb_port_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the shared write port.
// Ports: Clk, Rst (async low), ReqA/ReqB in, GntA/GntB out (comb).
module wb_rr_arbiter
  import regfile_wb_ctrl_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic ReqA,
  input  logic ReqB,
  output logic GntA,
  output logic GntB
);

  wb_port_e lastWin;
  logic     both;

  assign both = ReqA && ReqB;

  always_comb begin
    GntA = 1'b0;
    GntB = 1'b0;
    unique case (1'b1)
      both: begin
        if (lastWin == PORT_B) begin
          GntA = 1'b1;
        end else begin
          GntB = 1'b1;
        end
      end
      (ReqA && !ReqB): GntA = 1'b1;
      (!ReqA && ReqB): GntB = 1'b1;
      default: ;
    endcase
  end

  // Pointer moves only on contention so a lone
  // requester never costs the other port its turn.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lastWin <= PORT_B;
    end else if (both) begin
      lastWin <= GntA ? PORT_A : PORT_B;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: arbitrates pipeline (A) and
// long-latency (B) writebacks, keeps the port-B busy scoreboard.
// Ports: A/B valid-ready writeback, Issue dispatch, Rs1/Rs2 hazard
// lookup, registered RdWrite* outputs to the register file.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int REG_NUM = WB_REG_NUM
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              AValid,
  input  logic [ADDR_W-1:0] AAddr,
  input  logic [DATA_W-1:0] AData,
  output logic              AReady,
  input  logic              BValid,
  input  logic [ADDR_W-1:0] BAddr,
  input  logic [DATA_W-1:0] BData,
  output logic              BReady,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic              IssueReady,
  input  logic [ADDR_W-1:0] Rs1Addr,
  input  logic [ADDR_W-1:0] Rs2Addr,
  output logic              Rs1Busy,
  output logic              Rs2Busy,
  output logic              RdWriteEnable,
  output logic [ADDR_W-1:0] RdWriteAddr,
  output logic [DATA_W-1:0] RdWriteData
);

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(ZERO_REG);

  logic               gntA;
  logic               gntB;
  logic               anyGnt;
  logic [ADDR_W-1:0]  selAddr;
  logic [DATA_W-1:0]  selData;
  logic               selEn;
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busyNext;
  logic               issueFire;

  wb_rr_arbiter uArb (
    .Clk  (Clk),
    .Rst  (Rst),
    .ReqA (AValid),
    .ReqB (BValid),
    .GntA (gntA),
    .GntB (gntB)
  );

  assign AReady = gntA;
  assign BReady = gntB;
  assign anyGnt = gntA || gntB;

  always_comb begin
    selAddr = RdWriteAddr;
    selData = RdWriteData;
    unique case (1'b1)
      gntA: begin
        selAddr = AAddr;
        selData = AData;
      end
      gntB: begin
        selAddr = BAddr;
        selData = BData;
      end
      default: ;
    endcase
  end

  // x0 writes are accepted but never reach the register file.
  assign selEn = anyGnt && (selAddr != X0);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RdWriteEnable <= 1'b0;
      RdWriteAddr   <= '0;
      RdWriteData   <= '0;
    end else begin
      RdWriteEnable <= selEn;
      if (anyGnt) begin
        RdWriteAddr <= selAddr;
        RdWriteData <= selData;
      end
    end
  end

  assign IssueReady = !busy[IssueAddr];
  assign issueFire  = IssueValid && IssueReady;

  // Clear first, then set, so a same-cycle issue to the
  // register B is retiring keeps it busy for the new op.
  always_comb begin
    busyNext = busy;
    if (gntB && (BAddr != X0)) begin
      busyNext[BAddr] = 1'b0;
    end
    if (issueFire && (IssueAddr != X0)) begin
      busyNext[IssueAddr] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  // Registered state only: a clear this cycle still reads busy.
  assign Rs1Busy = busy[Rs1Addr];
  assign Rs2Busy = busy[Rs2Addr];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with an expected-write queue.
// Grant/busy reference kept in bench variables, checked by assertions.
module tb_regfile_wb_ctrl;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic        Clk;
  logic        Rst;
  logic        AValid;
  logic [4:0]  AAddr;
  logic [63:0] AData;
  logic        AReady;
  logic        BValid;
  logic [4:0]  BAddr;
  logic [63:0] BData;
  logic        BReady;
  logic        IssueValid;
  logic [4:0]  IssueAddr;
  logic        IssueReady;
  logic [4:0]  Rs1Addr;
  logic [4:0]  Rs2Addr;
  logic        Rs1Busy;
  logic        Rs2Busy;
  logic        RdWriteEnable;
  logic [4:0]  RdWriteAddr;
  logic [63:0] RdWriteData;

  int errors = 0;
  int checks = 0;

  wr_t         q[$];
  logic [31:0] mBusy;
  logic        mPtrB;
  logic [4:0]  mAddr;
  logic [63:0] mData;

  regfile_wb_ctrl dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .AValid        (AValid),
    .AAddr         (AAddr),
    .AData         (AData),
    .AReady        (AReady),
    .BValid        (BValid),
    .BAddr         (BAddr),
    .BData         (BData),
    .BReady        (BReady),
    .IssueValid    (IssueValid),
    .IssueAddr     (IssueAddr),
    .IssueReady    (IssueReady),
    .Rs1Addr       (Rs1Addr),
    .Rs2Addr       (Rs2Addr),
    .Rs1Busy       (Rs1Busy),
    .Rs2Busy       (Rs2Busy),
    .RdWriteEnable (RdWriteEnable),
    .RdWriteAddr   (RdWriteAddr),
    .RdWriteData   (RdWriteData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    AValid     = 1'b0;
    BValid     = 1'b0;
    IssueValid = 1'b0;
  endtask

  task automatic model_reset();
    mBusy = '0;
    mPtrB = 1'b1;
    mAddr = '0;
    mData = '0;
    q.delete();
  endtask

  // One clock: drive at posedge+1, check handshake at negedge,
  // check register-file outputs at next posedge+1.
  task automatic step(input logic av, input logic [4:0] aa,
                      input logic [63:0] ad,
                      input logic bv, input logic [4:0] ba,
                      input logic [63:0] bd,
                      input logic iv, input logic [4:0] ia);
    logic        eA;
    logic        eB;
    logic        eIr;
    logic [31:0] nb;
    wr_t         w;
    wr_t         got;
    AValid     = av;
    AAddr      = aa;
    AData      = ad;
    BValid     = bv;
    BAddr      = ba;
    BData      = bd;
    IssueValid = iv;
    IssueAddr  = ia;
    @(negedge Clk);
    eA  = av && (!bv || mPtrB);
    eB  = bv && (!av || !mPtrB);
    eIr = !mBusy[ia];
    chk("AReady", 64'(AReady), 64'(eA));
    chk("BReady", 64'(BReady), 64'(eB));
    chk("IssueReady", 64'(IssueReady), 64'(eIr));
    chk("Rs1Busy", 64'(Rs1Busy), 64'(mBusy[Rs1Addr]));
    chk("Rs2Busy", 64'(Rs2Busy), 64'(mBusy[Rs2Addr]));
    if (eA) begin
      mAddr = aa;
      mData = ad;
    end else if (eB) begin
      mAddr = ba;
      mData = bd;
    end
    w.en   = (eA || eB) && (mAddr != 5'd0);
    w.addr = mAddr;
    w.data = mData;
    q.push_back(w);
    if (av && bv) mPtrB = eB;
    nb = mBusy;
    if (eB && ba != 5'd0) nb[ba] = 1'b0;
    if (iv && eIr && ia != 5'd0) nb[ia] = 1'b1;
    @(posedge Clk);
    #1;
    mBusy = nb;
    if (q.size() == 0) begin
      chk("queue_empty", 64'd1, 64'd0);
    end else begin
      got = q.pop_front();
      chk("RdWriteEnable", 64'(RdWriteEnable), 64'(got.en));
      chk("RdWriteAddr", 64'(RdWriteAddr), 64'(got.addr));
      chk("RdWriteData", RdWriteData, got.data);
    end
  endtask

  initial begin
    Rst     = 1'b0;
    AAddr   = '0;
    AData   = '0;
    BAddr   = '0;
    BData   = '0;
    IssueAddr = '0;
    Rs1Addr = '0;
    Rs2Addr = '0;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_en", 64'(RdWriteEnable), 64'd0);
    chk("rst_addr", 64'(RdWriteAddr), 64'd0);
    chk("rst_data", RdWriteData, 64'd0);
    chk("rst_busy", 64'(Rs1Busy), 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;

    // single port A write
    step(1, 5'd5, 64'h1234, 0, 0, 0, 0, 0);
    chk("single_en", 64'(RdWriteEnable), 64'd1);
    chk("single_addr", 64'(RdWriteAddr), 64'd5);
    chk("single_data", RdWriteData, 64'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // contention: expect A,B,A,B
    for (int i = 0; i < 4; i++) begin
      step(1, 5'd3, 64'hAA, 1, 5'd4, 64'hBB, 0, 0);
      chk("contend_addr", 64'(RdWriteAddr),
          (i % 2 == 0) ? 64'd3 : 64'd4);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // scoreboard on x7
    Rs1Addr = 5'd7;
    step(0, 0, 0, 0, 0, 0, 1, 5'd7);
    step(0, 0, 0, 0, 0, 0, 0, 5'd7);
    chk("x7_busy", 64'(Rs1Busy), 64'd1);
    chk("x7_issue_rdy", 64'(IssueReady), 64'd0);
    step(0, 0, 0, 1, 5'd7, 64'h77, 0, 5'd7);
    chk("x7_cleared", 64'(Rs1Busy), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // same-cycle B retire and issue to x9: set wins
    Rs2Addr = 5'd9;
    step(0, 0, 0, 1, 5'd9, 64'h99, 1, 5'd9);
    chk("x9_set_wins", 64'(Rs2Busy), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 5'd9);

    // zero register
    Rs1Addr = 5'd0;
    step(0, 0, 0, 0, 0, 0, 1, 5'd0);
    step(0, 0, 0, 0, 0, 0, 0, 5'd0);
    chk("x0_busy", 64'(Rs1Busy), 64'd0);
    step(1, 5'd0, 64'hDEAD, 0, 0, 0, 0, 0);
    chk("x0_no_write", 64'(RdWriteEnable), 64'd0);

    // mid-traffic reset after A wins a contention
    Rs1Addr = 5'd12;
    step(0, 0, 0, 0, 0, 0, 1, 5'd12);
    step(1, 5'd3, 64'hA1, 1, 5'd4, 64'hB1, 0, 0);
    chk("pre_rst_en", 64'(RdWriteEnable), 64'd1);
    idle_inputs();
    Rst = 1'b0;
    #1;
    chk("mid_rst_en", 64'(RdWriteEnable), 64'd0);
    chk("mid_rst_addr", 64'(RdWriteAddr), 64'd0);
    chk("mid_rst_data", RdWriteData, 64'd0);
    chk("mid_rst_busy12", 64'(Rs1Busy), 64'd0);
    chk("mid_rst_busy9", 64'(Rs2Busy), 64'd0);
    model_reset();
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    step(1, 5'd3, 64'hA2, 1, 5'd4, 64'hB2, 0, 0);
    chk("post_rst_first_a", 64'(RdWriteAddr), 64'd3);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
